// File: rtl/formula_fsm_pkg.sv
// Shared types for the nested-isqrt formula sequencer.
package formula_fsm_pkg;

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} formula_state_t;

  // Step counter width: $clog2(n_terms), never narrower than one bit.
  function automatic int calc_step_w(input int n_terms);
    return (n_terms > 1) ? $clog2(n_terms) : 1;
  endfunction

endpackage

// File: rtl/formula_nested_sqrt_fsm.sv
// Evaluates isqrt(x[0] + isqrt(x[1] + ... isqrt(x[N_TERMS-1]))) through one shared
// external isqrt unit, issuing one request at a time from the innermost term out.
module formula_nested_sqrt_fsm
  import formula_fsm_pkg::*;
#(
  parameter int N_TERMS = 3,
  parameter int W       = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      arg_vld,
  output logic                      arg_rdy,
  input  logic [N_TERMS-1:0][W-1:0] args,
  output logic                      res_vld,
  input  logic                      res_rdy,
  output logic [W-1:0]              res,
  output logic                      isqrt_x_vld,
  output logic [W-1:0]              isqrt_x,
  input  logic                      isqrt_y_vld,
  input  logic [W/2-1:0]            isqrt_y
);

  localparam int                STEP_W    = calc_step_w(N_TERMS);
  localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(N_TERMS - 1);

  formula_state_t             state, state_nxt;
  logic [STEP_W-1:0]          step;
  logic [N_TERMS-1:0][W-1:0]  args_q;
  logic [W-1:0]               term;
  logic [W-1:0]               op_nxt;
  logic                       last;

  assign last = (step == LAST_STEP);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (arg_vld) state_nxt = REQ;
      REQ:     state_nxt = WAIT;
      WAIT:    if (isqrt_y_vld) state_nxt = last ? DONE : REQ;
      DONE:    if (res_rdy) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    arg_rdy     = (state == IDLE);
    isqrt_x_vld = (state == REQ);
    res_vld     = (state == DONE);
  end

  // Next operand uses the term one level further out than the current step.
  always_comb begin
    term = '0;
    for (int i = 0; i < N_TERMS; i++)
      if (i + 2 + int'(step) == N_TERMS) term = args_q[i];
  end

  assign op_nxt = term + W'(isqrt_y);

  always_ff @(posedge clk) begin
    if (state == IDLE && arg_vld) args_q <= args;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      step    <= '0;
      isqrt_x <= '0;
      res     <= '0;
    end else begin
      case (state)
        IDLE: if (arg_vld) begin
          step    <= '0;
          isqrt_x <= args[N_TERMS-1];
        end
        WAIT: if (isqrt_y_vld) begin
          if (last) begin
            res <= W'(isqrt_y);
          end else begin
            step    <= step + 1'b1;
            isqrt_x <= op_nxt;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
